// File: rtl/mesh_sort_ctrl.sv
// Shearsort sequencer for a 2-D PE mesh: broadcasts row/column phase codes on
// the shared state bus and drives the PE load strobe between start and done.
module mesh_sort_ctrl #(
  parameter int         TOTAL_ROW_COUNT = 4,
  parameter int         TOTAL_COL_COUNT = 4,
  parameter int         ROUNDS          = 3,
  parameter logic [3:0] IDLE_CODE       = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  output logic [3:0] state,
  output logic       pe_rst,
  output logic       busy,
  output logic       done,
  output logic [1:0] phase,
  output logic [3:0] round
);

  localparam int MAX_STEPS = (TOTAL_ROW_COUNT > TOTAL_COL_COUNT) ? TOTAL_ROW_COUNT : TOTAL_COL_COUNT;
  localparam int SW        = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  localparam logic [SW-1:0] ROW_LAST   = SW'(TOTAL_COL_COUNT - 1);
  localparam logic [SW-1:0] COL_LAST   = SW'(TOTAL_ROW_COUNT - 1);
  localparam logic [SW-1:0] STEP_ZERO  = SW'(0);
  localparam logic [SW-1:0] STEP_ONE   = SW'(1);
  localparam logic [3:0]    LAST_ROUND = 4'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ROW  = 3'd2,
    S_COL  = 3'd3,
    S_DONE = 3'd4
  } fsm_e;

  fsm_e          r_fsm;
  logic [SW-1:0] r_step;
  logic [3:0]    r_state;
  logic          r_pe_rst;
  logic          r_busy;
  logic          r_done;
  logic [1:0]    r_phase;
  logic [3:0]    r_round;
  logic [SW-1:0] w_step_nxt;

  assign w_step_nxt = r_step + STEP_ONE;

  // Sequencer FSM; every output is registered alongside the state it belongs to.
  // r_step is the step whose code is currently on the bus, so a held step
  // resumes with the next code that was pending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fsm    <= S_IDLE;
      r_step   <= STEP_ZERO;
      r_state  <= IDLE_CODE;
      r_pe_rst <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_phase  <= 2'd0;
      r_round  <= 4'd0;
    end else begin
      r_pe_rst <= 1'b0;
      r_done   <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          r_state <= IDLE_CODE;
          r_phase <= 2'd0;
          if (start) begin
            r_fsm    <= S_LOAD;
            r_pe_rst <= 1'b1;
            r_busy   <= 1'b1;
          end else begin
            r_fsm  <= S_IDLE;
            r_busy <= 1'b0;
          end
        end
        S_LOAD: begin
          r_fsm   <= S_ROW;
          r_step  <= STEP_ZERO;
          r_round <= 4'd0;
          r_state <= 4'd3;
          r_phase <= 2'd1;
          r_busy  <= 1'b1;
        end
        S_ROW: begin
          if (hold) begin
            r_state <= IDLE_CODE;
          end else if (r_step == ROW_LAST) begin
            if (r_round == LAST_ROUND) begin
              r_fsm   <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE_CODE;
              r_phase <= 2'd0;
            end else begin
              r_fsm   <= S_COL;
              r_step  <= STEP_ZERO;
              r_state <= 4'd5;
              r_phase <= 2'd2;
            end
          end else begin
            r_step  <= w_step_nxt;
            r_state <= w_step_nxt[0] ? 4'd2 : 4'd3;
          end
        end
        S_COL: begin
          if (hold) begin
            r_state <= IDLE_CODE;
          end else if (r_step == COL_LAST) begin
            r_fsm   <= S_ROW;
            r_step  <= STEP_ZERO;
            r_round <= r_round + 4'd1;
            r_state <= 4'd3;
            r_phase <= 2'd1;
          end else begin
            r_step  <= w_step_nxt;
            r_state <= w_step_nxt[0] ? 4'd4 : 4'd5;
          end
        end
        S_DONE: begin
          r_fsm   <= S_IDLE;
          r_state <= IDLE_CODE;
          r_busy  <= 1'b0;
          r_phase <= 2'd0;
        end
        default: begin
          r_fsm   <= S_IDLE;
          r_step  <= STEP_ZERO;
          r_state <= IDLE_CODE;
          r_busy  <= 1'b0;
          r_phase <= 2'd0;
          r_round <= 4'd0;
        end
      endcase
    end
  end

  assign state  = r_state;
  assign pe_rst = r_pe_rst;
  assign busy   = r_busy;
  assign done   = r_done;
  assign phase  = r_phase;
  assign round  = r_round;

endmodule

// File: tb/tb_mesh_sort_ctrl.sv
// Directed bench for mesh_sort_ctrl: per-cycle code/handshake expectations plus
// a behavioural 4x4 PE grid driven by the controller to check the sort result.
module tb_mesh_sort_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, hold;
  logic [3:0] state, round;
  logic       pe_rst, busy, done;
  logic [1:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] grid    [16];
  logic [7:0] pre_val [16];
  int codes [20] = '{3,2,3,2, 5,4,5,4, 3,2,3,2, 5,4,5,4, 3,2,3,2};

  always #5 clk = ~clk;

  mesh_sort_ctrl #(
    .TOTAL_ROW_COUNT(4),
    .TOTAL_COL_COUNT(4),
    .ROUNDS(3),
    .IDLE_CODE(4'hF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .state(state), .pe_rst(pe_rst), .busy(busy), .done(done),
    .phase(phase), .round(round)
  );

  // PE grid model: load on pe_rst, otherwise compare-exchange per phase code.
  // Even rows sort ascending, odd rows descending, columns ascending downward.
  always @(posedge clk) begin
    if (pe_rst) begin
      for (int i = 0; i < 16; i++) grid[i] <= pre_val[i];
    end else if (state == 4'd3 || state == 4'd2) begin
      for (int r = 0; r < 4; r++)
        for (int c = (state == 4'd3) ? 0 : 1; c + 1 < 4; c += 2)
          if ((r % 2 == 0) ? (grid[r*4+c] > grid[r*4+c+1]) : (grid[r*4+c] < grid[r*4+c+1])) begin
            grid[r*4+c]   <= grid[r*4+c+1];
            grid[r*4+c+1] <= grid[r*4+c];
          end
    end else if (state == 4'd5 || state == 4'd4) begin
      for (int c = 0; c < 4; c++)
        for (int r = (state == 4'd5) ? 0 : 1; r + 1 < 4; r += 2)
          if (grid[r*4+c] > grid[(r+1)*4+c]) begin
            grid[r*4+c]     <= grid[(r+1)*4+c];
            grid[(r+1)*4+c] <= grid[r*4+c];
          end
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One sort, observed for cycles 1..32 after a start driven in cycle 0.
  // hold is seen at the edges opening cycles hs..hs+hn-1; start pulses sa/sb are
  // driven during those cycles; rst_at>0 drops reset during that cycle.
  task automatic run_seq(input string name, input int hs, input int hn,
                         input int sa, input int sb, input int rst_at);
    int held, n_done, k;
    int e_state, e_busy, e_done, e_pe, e_phase, e_round;
    bit chk_pr;
    held   = 0;
    n_done = 0;
    start  = 1'b1;
    hold   = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #1;
      if (done) n_done++;
      chk_pr  = 1'b0;
      e_round = 0;
      if (rst_at > 0 && c > rst_at) begin
        e_state = 15; e_busy = 0; e_done = 0; e_pe = (c == rst_at + 1) ? 1 : 0; e_phase = 0;
      end else if (c == 1) begin
        e_state = 15; e_busy = 1; e_done = 0; e_pe = 1; e_phase = 0;
      end else if (c >= hs && c < hs + hn) begin
        e_state = 15; e_busy = 1; e_done = 0; e_pe = 0; e_phase = 0;
        held++;
      end else begin
        k = c - 2 - held;
        e_pe = 0;
        if (k < 20) begin
          e_state = codes[k]; e_busy = 1; e_done = 0;
          e_phase = ((k / 4) % 2 == 0) ? 1 : 2;
          e_round = k / 8;
          chk_pr  = 1'b1;
        end else begin
          e_state = 15; e_busy = 0; e_done = (k == 20) ? 1 : 0; e_phase = 0;
        end
      end
      check_eq($sformatf("%s c%0d state", name, c), int'(state), e_state);
      check_eq($sformatf("%s c%0d busy", name, c), int'(busy), e_busy);
      check_eq($sformatf("%s c%0d done", name, c), int'(done), e_done);
      check_eq($sformatf("%s c%0d pe_rst", name, c), int'(pe_rst), e_pe);
      if (chk_pr || e_busy == 0) check_eq($sformatf("%s c%0d phase", name, c), int'(phase), e_phase);
      if (chk_pr) check_eq($sformatf("%s c%0d round", name, c), int'(round), e_round);
      start = (c == sa || c == sb);
      hold  = (c + 1 >= hs && c + 1 < hs + hn);
      rst   = (c != rst_at);
    end
    check_eq($sformatf("%s done_pulses", name), n_done, (rst_at > 0) ? 0 : 1);
    start = 1'b0;
    hold  = 1'b0;
    rst   = 1'b1;
  endtask

  initial begin
    int r, col;
    for (int i = 0; i < 16; i++) pre_val[i] = 8'(15 - i);
    rst = 1'b0; start = 1'b0; hold = 1'b0;

    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_eq("rst state", int'(state), 15);
      check_eq("rst pe_rst", int'(pe_rst), 1);
      check_eq("rst busy", int'(busy), 0);
      check_eq("rst done", int'(done), 0);
      check_eq("rst phase", int'(phase), 0);
      check_eq("rst round", int'(round), 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("idle state", int'(state), 15);
      check_eq("idle pe_rst", int'(pe_rst), 0);
      check_eq("idle busy", int'(busy), 0);
      check_eq("idle done", int'(done), 0);
    end

    run_seq("nominal", 0, 0, -1, -1, 0);
    for (int k = 0; k < 16; k++) begin
      r   = k / 4;
      col = (r % 2 == 0) ? (k % 4) : (3 - k % 4);
      check_eq($sformatf("snake[%0d]", k), int'(grid[r*4+col]), k);
    end

    run_seq("hold", 7, 3, -1, -1, 0);
    run_seq("abort", 0, 0, -1, -1, 10);
    run_seq("rerun", 0, 0, -1, -1, 0);
    run_seq("extra_start", 0, 0, 5, 22, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
